// File: rtl/inst_fetch.sv
// Instruction fetch unit: reads bytes over an 8-bit program memory port and
// assembles 1- or 2-byte instructions held under a valid/ready handshake.
module inst_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [1:0]  inst_bytes,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  b0_q, b0_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic [1:0]  inst_bytes_q, inst_bytes_d;

  logic        acked;
  logic [15:0] pc_inc;

  // An ack only counts against a request we are actually driving.
  assign acked  = mem_req_q & mem_ack;
  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    b0_d         = b0_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_bytes_d = inst_bytes_q;

    if (redirect) begin
      // Flush wins over everything, including a same-cycle ack.
      state_d      = FETCH_HI;
      pc_d         = redirect_pc;
      mem_req_d    = 1'b1;
      mem_addr_d   = redirect_pc;
      inst_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = FETCH_HI;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
        FETCH_HI: begin
          if (acked) begin
            b0_d = mem_data;
            pc_d = pc_inc;
            if (mem_data[7]) begin
              state_d    = FETCH_LO;
              mem_addr_d = pc_inc;
            end else begin
              state_d      = HOLD;
              mem_req_d    = 1'b0;
              inst_valid_d = 1'b1;
              inst_d       = {mem_data, 8'h00};
              inst_pc_d    = pc_q;
              inst_bytes_d = 2'd1;
            end
          end
        end
        FETCH_LO: begin
          if (acked) begin
            state_d      = HOLD;
            pc_d         = pc_inc;
            mem_req_d    = 1'b0;
            inst_valid_d = 1'b1;
            inst_d       = {b0_q, mem_data};
            inst_pc_d    = pc_q - 16'd1;
            inst_bytes_d = 2'd2;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            state_d      = FETCH_HI;
            mem_req_d    = 1'b1;
            mem_addr_d   = pc_q;
            inst_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      b0_q         <= 8'h00;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 16'h0000;
      inst_pc_q    <= RESET_PC;
      inst_bytes_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      b0_q         <= b0_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_bytes_q <= inst_bytes_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_bytes = inst_bytes_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus a randomized run checked
// against an instruction-stream model derived from memory contents.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack, inst_valid, inst_ready, redirect;
  logic [15:0] mem_addr, inst, inst_pc, redirect_pc;
  logic [7:0]  mem_data;
  logic [1:0]  inst_bytes;

  // Second instance with a wrapping reset PC, driven by hand.
  logic        mem_req_w, mem_ack_w, inst_valid_w, inst_ready_w, redirect_w;
  logic [15:0] mem_addr_w, inst_w, inst_pc_w, redirect_pc_w;
  logic [7:0]  mem_data_w;
  logic [1:0]  inst_bytes_w;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          fixed_wait = 0;
  bit          rand_wait  = 1'b0;
  bit          spurious   = 1'b0;

  wire [16:0] req_obs    = {mem_req, mem_addr};
  wire [34:0] inst_obs   = {inst_valid, inst, inst_pc, inst_bytes};
  wire [16:0] req_obs_w  = {mem_req_w, mem_addr_w};
  wire [34:0] inst_obs_w = {inst_valid_w, inst_w, inst_pc_w, inst_bytes_w};

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_bytes(inst_bytes),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  inst_fetch #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_data(mem_data_w),
    .inst_valid(inst_valid_w), .inst_ready(inst_ready_w), .inst(inst_w),
    .inst_pc(inst_pc_w), .inst_bytes(inst_bytes_w),
    .redirect(redirect_w), .redirect_pc(redirect_pc_w)
  );

  // Memory responder: acts just after the falling edge, so at the falling
  // edge mem_ack still shows what the DUT saw on the last rising edge.
  initial begin
    int cnt;
    int cur_wait;
    cnt = 0;
    cur_wait = 0;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !mem_req) begin
        cnt = 0;
        if (spurious && rst_n) begin
          mem_ack  = 1'($urandom_range(0, 1));
          mem_data = 8'($urandom);
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        if (mem_ack) cnt = 0;
        if (cnt == 0) cur_wait = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
        if (cnt >= cur_wait) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
        end else begin
          mem_ack  = 1'b0;
          mem_data = 8'($urandom);
          cnt++;
        end
      end
    end
  end

  // Bring the main DUT to a held instruction with inst_ready low.
  task automatic park();
    int i;
    inst_ready = 1'b0;
    for (i = 0; i < 100 && !inst_valid; i++) @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL park_timeout: inst_valid=%b required 1 within 100 cycles", inst_valid);
    end
  endtask

  // Redirect from a parked state; returns at the first cycle of the new request.
  task automatic redirect_to(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if ({req_obs, inst_valid} !== {1'b1, pc, 1'b0}) begin
      n_fail++;
      $display("FAIL redirect_latency: req/addr/valid=%h required %h", {req_obs, inst_valid}, {1'b1, pc, 1'b0});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_ack_w = 1'b0; mem_data_w = 8'h00; inst_ready_w = 1'b0;
    redirect_w = 1'b0; redirect_pc_w = 16'h0000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_obs, inst_obs} !== {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h", {req_obs, inst_obs},
               {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0});
    end
    n_checks++;
    if ({req_obs_w, inst_obs_w} !== {1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_values_wrap: got %h required %h", {req_obs_w, inst_obs_w},
               {1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 2'd0});
    end
    rst_n = 1'b1;
    inst_ready = 1'b1;
  endtask

  task automatic test_zero_wait();
    logic [16:0] exp_req [4]  = '{{1'b1, 16'h0000}, {1'b1, 16'h0001}, {1'b1, 16'h0002}, {1'b1, 16'h0003}};
    fixed_wait = 0;
    @(negedge clk);
    n_checks++;
    if (req_obs !== exp_req[0]) begin n_fail++; $display("FAIL first_req: got %h required %h", req_obs, exp_req[0]); end
    @(negedge clk);
    n_checks++;
    if ({mem_req, inst_obs} !== {1'b0, 1'b1, 16'h0100, 16'h0000, 2'd1}) begin
      n_fail++; $display("FAIL one_byte_inst: got %h required %h", {mem_req, inst_obs}, {1'b0, 1'b1, 16'h0100, 16'h0000, 2'd1});
    end
    @(negedge clk);
    n_checks++;
    if (req_obs !== exp_req[1]) begin n_fail++; $display("FAIL req_after_accept: got %h required %h", req_obs, exp_req[1]); end
    @(negedge clk);
    n_checks++;
    if (inst_obs !== {1'b1, 16'h0200, 16'h0001, 2'd1}) begin
      n_fail++; $display("FAIL second_inst: got %h required %h", inst_obs, {1'b1, 16'h0200, 16'h0001, 2'd1});
    end
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req_obs, inst_valid} !== {exp_req[k], 1'b0}) begin
        n_fail++; $display("FAIL two_byte_req%0d: got %h required %h", k, {req_obs, inst_valid}, {exp_req[k], 1'b0});
      end
    end
    @(negedge clk);
    n_checks++;
    if (inst_obs !== {1'b1, 16'h8805, 16'h0002, 2'd2}) begin
      n_fail++; $display("FAIL two_byte_inst: got %h required %h", inst_obs, {1'b1, 16'h8805, 16'h0002, 2'd2});
    end
    @(negedge clk);
    n_checks++;
    if (req_obs !== {1'b1, 16'h0004}) begin n_fail++; $display("FAIL req_after_two_byte: got %h required %h", req_obs, {1'b1, 16'h0004}); end
  endtask

  task automatic test_mem_wait();
    fixed_wait = 3;
    park();
    redirect_to(16'h0002);
    for (int k = 1; k < 8; k++) begin
      logic [15:0] want_addr;
      want_addr = (k < 4) ? 16'h0002 : 16'h0003;
      @(negedge clk);
      n_checks++;
      if ({req_obs, inst_valid} !== {1'b1, want_addr, 1'b0}) begin
        n_fail++; $display("FAIL wait_hold_addr k=%0d: got %h required %h", k, {req_obs, inst_valid}, {1'b1, want_addr, 1'b0});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({mem_req, inst_obs} !== {1'b0, 1'b1, 16'h8805, 16'h0002, 2'd2}) begin
      n_fail++; $display("FAIL wait_inst: got %h required %h", {mem_req, inst_obs}, {1'b0, 1'b1, 16'h8805, 16'h0002, 2'd2});
    end
    fixed_wait = 0;
  endtask

  task automatic test_hold();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_req, inst_obs} !== {1'b0, 1'b1, 16'h8805, 16'h0002, 2'd2}) begin
        n_fail++; $display("FAIL hold_stable k=%0d: got %h required %h", k, {mem_req, inst_obs}, {1'b0, 1'b1, 16'h8805, 16'h0002, 2'd2});
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    n_checks++;
    if ({req_obs, inst_valid} !== {1'b1, 16'h0004, 1'b0}) begin
      n_fail++; $display("FAIL hold_release: got %h required %h", {req_obs, inst_valid}, {1'b1, 16'h0004, 1'b0});
    end
  endtask

  task automatic test_redirect_lo();
    park();
    redirect_to(16'h0010);
    @(negedge clk);
    n_checks++;
    if (req_obs !== {1'b1, 16'h0011}) begin n_fail++; $display("FAIL redirect_lo_setup: got %h required %h", req_obs, {1'b1, 16'h0011}); end
    redirect_to(16'h1234);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    n_checks++;
    if (inst_obs !== {1'b1, 16'h1200, 16'h1234, 2'd1}) begin
      n_fail++; $display("FAIL redirect_lo_inst: got %h required %h", inst_obs, {1'b1, 16'h1200, 16'h1234, 2'd1});
    end
  endtask

  task automatic test_async_reset();
    fixed_wait = 5;
    park();
    redirect_to(16'h0020);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_obs, inst_obs} !== {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0}) begin
      n_fail++; $display("FAIL async_reset: got %h required %h", {req_obs, inst_obs},
                         {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    fixed_wait = 0;
    @(negedge clk);
    n_checks++;
    if (req_obs !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL post_reset_req: got %h required %h", req_obs, {1'b1, 16'h0000}); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    n_checks++;
    if (req_obs_w !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL wrap_req_hi: got %h required %h", req_obs_w, {1'b1, 16'hFFFF}); end
    mem_ack_w = 1'b1; mem_data_w = 8'hC0;
    @(negedge clk);
    n_checks++;
    if (req_obs_w !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL wrap_req_lo: got %h required %h", req_obs_w, {1'b1, 16'h0000}); end
    mem_data_w = 8'h10;
    @(negedge clk);
    mem_ack_w = 1'b0;
    n_checks++;
    if ({mem_req_w, inst_obs_w} !== {1'b0, 1'b1, 16'hC010, 16'hFFFF, 2'd2}) begin
      n_fail++; $display("FAIL wrap_inst: got %h required %h", {mem_req_w, inst_obs_w}, {1'b0, 1'b1, 16'hC010, 16'hFFFF, 2'd2});
    end
    inst_ready_w = 1'b1;
    @(negedge clk);
    inst_ready_w = 1'b0;
    n_checks++;
    if ({req_obs_w, inst_valid_w} !== {1'b1, 16'h0001, 1'b0}) begin
      n_fail++; $display("FAIL wrap_next_req: got %h required %h", {req_obs_w, inst_valid_w}, {1'b1, 16'h0001, 1'b0});
    end
  endtask

  // Randomized run: the model walks memory from the last redirect target,
  // one decoded instruction per accepted handshake.
  task automatic test_random();
    logic [15:0] model_pc, prev_addr, prev_rpc, next_pc;
    logic [7:0]  b0;
    logic [34:0] want;
    bit          prev_req, prev_redir, rdy, redir;
    int          consumed;
    rand_wait = 1'b1;
    spurious  = 1'b1;
    park();
    model_pc = 16'($urandom_range(0, 511));
    redirect_to(model_pc);
    prev_req = 1'b1; prev_addr = model_pc; prev_redir = 1'b0; prev_rpc = model_pc;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_redir) begin
        n_checks++;
        if ({req_obs, inst_valid} !== {1'b1, prev_rpc, 1'b0}) begin
          n_fail++; $display("FAIL rand_redirect cyc=%0d: got %h required %h", cyc, {req_obs, inst_valid}, {1'b1, prev_rpc, 1'b0});
        end
      end else if (prev_req && !mem_ack) begin
        n_checks++;
        if (req_obs !== {1'b1, prev_addr}) begin
          n_fail++; $display("FAIL rand_addr_stable cyc=%0d: got %h required %h", cyc, req_obs, {1'b1, prev_addr});
        end
      end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 39) == 0);
      inst_ready  = rdy;
      redirect    = redir;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 511));
      if (inst_valid && rdy) begin
        b0      = mem[model_pc];
        next_pc = model_pc + 16'd1;
        want    = b0[7] ? {1'b1, b0, mem[next_pc], model_pc, 2'd2} : {1'b1, b0, 8'h00, model_pc, 2'd1};
        n_checks++;
        if (inst_obs !== want) begin
          n_fail++; $display("FAIL rand_inst cyc=%0d: got %h required %h", cyc, inst_obs, want);
        end
        model_pc = model_pc + (b0[7] ? 16'd2 : 16'd1);
        consumed++;
      end
      if (redir) model_pc = redirect_pc;
      prev_req = mem_req; prev_addr = mem_addr; prev_redir = redir; prev_rpc = redirect_pc;
    end
    @(negedge clk);
    inst_ready = 1'b0; redirect = 1'b0;
    rand_wait = 1'b0; spurious = 1'b0;
    n_checks++;
    if (consumed < 100) begin
      n_fail++; $display("FAIL rand_throughput: consumed %0d required at least 100", consumed);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02;
    mem[16'h0002] = 8'h88; mem[16'h0003] = 8'h05;
    mem[16'h0010] = 8'h90; mem[16'h0011] = 8'h33;
    mem[16'h1234] = 8'h12;
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_hold();
    test_redirect_lo();
    test_async_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
